ifu_fetch: RTL and testbench



---
 rtl/ifu_fetch.sv | 160 ++++++++++++++++
 tb/tb_ifu_fetch.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit.
// Holds the PC, keeps at most one request outstanding on the instruction-memory
// interface and hands the selected 32-bit half of the returned 64-bit word to
// decode under a valid/ready handshake. Execute redirects override everything
// and cause any stale response or held instruction to be thrown away.
// Optional feature macro: IFU_PERF_EN adds perf_fetch_cnt / perf_drop_cnt.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high; valid never waits on ready. imem_req_valid and inst_valid are
// forced low in any cycle where redirect_valid is high, so a redirect never
// coincides with a transfer.
module ifu_fetch #(
    parameter int unsigned     ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h8000_0000,
    parameter int unsigned     INST_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [63:0]       imem_resp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc
`ifdef IFU_PERF_EN
    ,
    output logic [63:0]       perf_fetch_cnt,
    output logic [63:0]       perf_drop_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              drop_q, drop_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic [ADDR_W-1:0] redir_pc_aligned;

    // Redirect targets are always treated as 4-byte aligned.
    assign redir_pc_aligned = redirect_pc & ~ADDR_W'(3);

    // Next-state, next-PC and instruction-latch logic for the fetch FSM.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d = redir_pc_aligned;
                end else if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (drop_q || redirect_valid) begin
                        // Stale or overridden response: throw it away and refetch.
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d    = pc_q[2] ? imem_resp_data[63:32] : imem_resp_data[31:0];
                        inst_pc_d = pc_q;
                        state_d   = S_HOLD;
                    end
                    if (redirect_valid) begin
                        pc_d = redir_pc_aligned;
                    end
                end else if (redirect_valid) begin
                    // Response still in flight; remember to discard it.
                    pc_d   = redir_pc_aligned;
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redir_pc_aligned;
                    state_d = S_REQ;
                end else if (inst_ready) begin
                    pc_d    = pc_q + ADDR_W'(4);
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // FSM state, PC, drop flag and held instruction registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            drop_q    <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            drop_q    <= drop_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    // Handshake outputs are suppressed in any redirect cycle.
    always_comb begin
        imem_req_valid = (state_q == S_REQ) && !redirect_valid && !rst;
        inst_valid     = (state_q == S_HOLD) && !redirect_valid;
    end

    assign imem_req_addr = {pc_q[ADDR_W-1:3], 3'b000};
    assign inst          = inst_q;
    assign inst_pc       = inst_pc_q;

`ifdef IFU_PERF_EN
    logic        fetch_evt;
    logic        drop_evt;
    logic [63:0] perf_fetch_q, perf_fetch_d;
    logic [63:0] perf_drop_q, perf_drop_d;

    // Count decode handshakes and discarded responses / held instructions.
    always_comb begin
        fetch_evt    = (state_q == S_HOLD) && !redirect_valid && inst_ready;
        drop_evt     = ((state_q == S_WAIT) && imem_resp_valid && (drop_q || redirect_valid))
                    || ((state_q == S_HOLD) && redirect_valid);
        perf_fetch_d = perf_fetch_q + (fetch_evt ? 64'd1 : 64'd0);
        perf_drop_d  = perf_drop_q + (drop_evt ? 64'd1 : 64'd0);
    end

    // Performance counter registers; both wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_drop_q  <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_drop_q  <= perf_drop_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_drop_cnt  = perf_drop_q;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch: architectural reference model (sequential PC stream
// with redirects) feeding an expected queue, a memory responder with variable
// latency, and a negedge monitor that scores every decode handshake.
module tb_ifu_fetch;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [63:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
`ifdef IFU_PERF_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_drop_cnt;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc)
`ifdef IFU_PERF_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_drop_cnt   (perf_drop_cnt)
`endif
    );

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory contents: fixed word at the reset vector, hashed elsewhere.
    function automatic logic [63:0] word_at(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h00100093_00000513;
        return {a[31:0] ^ 32'h1357_9BDF, a[63:32] ^ (a[31:0] * 32'h9E37_79B1)};
    endfunction

    // Expected {pc, inst} for an architectural PC.
    function automatic logic [95:0] expect_of(input logic [63:0] pc);
        logic [63:0] w;
        w = word_at({pc[63:3], 3'b000});
        return {pc, (pc[2] ? w[63:32] : w[31:0])};
    endfunction

    // ---------------- reference model / scoreboard state ----------------
    logic [95:0] exp_q[$];
    logic [63:0] model_pc;
    int          hs_cnt;
    int          hs_total = 0;
    int          acc_cnt;
    int          idle_cycles = 0;
    bit          watch_en = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_inst;
    logic [63:0] prev_inst_pc;

    // Memory responder state (set by monitor on accept, consumed by driver).
    bit          mem_pending = 0;
    logic [63:0] mem_addr;
    int          mem_cnt;
    int          mem_lat_cur;
    int          mem_lat = 1;
    bit          rand_lat = 0;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [95:0] got;
        if (rst) begin
            model_pc = RESET_PC;
            exp_q.delete();
            exp_q.push_back(expect_of(model_pc));
            hs_cnt      = 0;
            acc_cnt     = 0;
            prev_stall  = 0;
            idle_cycles = 0;
            check("rst_req_valid", imem_req_valid, 1'b0);
            check("rst_inst_valid", inst_valid, 1'b0);
        end else begin
            if (inst_valid) check("no_req_in_hold", imem_req_valid, 1'b0);
            if (prev_stall) begin
                check("hold_inst_stable", inst, prev_inst);
                check("hold_pc_stable", inst_pc, prev_inst_pc);
                check("hold_valid_kept", inst_valid, !redirect_valid);
            end
            if (redirect_valid) begin
                check("redir_inst_valid", inst_valid, 1'b0);
                check("redir_req_valid", imem_req_valid, 1'b0);
                model_pc = redirect_pc & ~64'd3;
                exp_q.delete();
                exp_q.push_back(expect_of(model_pc));
            end else if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    check("exp_q_empty", 1'b1, 1'b0);
                end else begin
                    got = exp_q.pop_front();
                    check("inst_pc", inst_pc, got[95:32]);
                    check("inst", inst, got[31:0]);
                end
                model_pc = model_pc + 64'd4;
                exp_q.push_back(expect_of(model_pc));
                hs_cnt++;
                hs_total++;
                idle_cycles = 0;
            end
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr", imem_req_addr, {model_pc[63:3], 3'b000});
                check("one_outstanding", mem_pending, 1'b0);
                mem_pending = 1;
                mem_addr    = imem_req_addr;
                mem_cnt     = 0;
                mem_lat_cur = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
                acc_cnt++;
            end
            prev_stall   = inst_valid && !inst_ready;
            prev_inst    = inst;
            prev_inst_pc = inst_pc;
            idle_cycles++;
            if (watch_en && idle_cycles > 300) begin
                check("progress_watchdog", 1'b0, 1'b1);
                idle_cycles = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Advance one cycle; inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        imem_resp_valid = 1'b0;
        if (mem_pending) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat_cur) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = word_at(mem_addr);
                mem_pending     = 0;
            end
        end
    endtask

    task automatic redirect_once(input logic [63:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_fresh_accept(input string name);
        int n;
        n = 0;
        while (!(mem_pending && mem_cnt == 1) && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) check(name, 1'b0, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        inst_ready      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_inst", inst, 32'h0);
        check("reset_inst_valid", inst_valid, 1'b0);
        check("reset_req_valid", imem_req_valid, 1'b0);
`ifdef IFU_PERF_EN
        check("reset_perf_fetch", perf_fetch_cnt, 64'd0);
        check("reset_perf_drop", perf_drop_cnt, 64'd0);
`endif
        rst = 1'b0;
        #1;
        check("first_req_valid", imem_req_valid, 1'b1);
        check("first_req_addr", imem_req_addr, 64'h8000_0000);

        // Straight-line fetch, 1-cycle memory.
        repeat (10) step();

        // Decoder stalls in HOLD.
        inst_ready = 1'b0;
        repeat (8) step();
        inst_ready = 1'b1;
        repeat (4) step();

        // Redirect while a 3-cycle response is in flight.
        mem_lat = 3;
        wait_fresh_accept("wait_accept_c");
        redirect_once(64'h8000_0100);
        repeat (10) step();
        mem_lat = 1;

        // Redirect while holding an instruction with decoder ready.
        inst_ready = 1'b0;
        n = 0;
        while (!inst_valid && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) check("wait_hold_d", 1'b0, 1'b1);
        inst_ready = 1'b1;
        redirect_once(64'h8000_0206);
        repeat (10) step();

        // Memory stalls requests; redirect during the stall.
        imem_req_ready = 1'b0;
        repeat (4) step();
        redirect_once(64'h8000_0340);
        repeat (2) step();
        imem_req_ready = 1'b1;
        repeat (8) step();

        // Randomized traffic including wrap-around redirects.
        rand_lat = 1;
        watch_en = 1;
        for (int i = 0; i < 3000; i++) begin
            step();
            inst_ready     = ($urandom_range(0, 3) != 0);
            imem_req_ready = ($urandom_range(0, 4) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 7) == 0)
                redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
            else
                redirect_pc = 64'h8000_0000 | 64'($urandom_range(0, 1023));
        end
        watch_en       = 0;
        rand_lat       = 0;
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        imem_req_ready = 1'b1;
        repeat (10) step();

        // Reset while waiting on a 4-cycle response; response lands after release.
        mem_lat = 4;
        wait_fresh_accept("wait_accept_g");
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
`ifdef IFU_PERF_EN
        check("post_reset_perf_fetch", perf_fetch_cnt, 64'd0);
        check("post_reset_perf_drop", perf_drop_cnt, 64'd0);
`endif
        repeat (3) step();
        imem_req_ready = 1'b1;
        mem_lat        = 1;
        repeat (12) step();

        // Drain to an idle REQ state, then audit totals.
        imem_req_ready = 1'b0;
        repeat (10) step();
        check("idle_no_pending", mem_pending, 1'b0);
        check("progress_total", (hs_total > 100), 1'b1);
`ifdef IFU_PERF_EN
        check("perf_fetch", perf_fetch_cnt, 64'(hs_cnt));
        check("perf_drop", perf_drop_cnt, 64'(acc_cnt - hs_cnt));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard time limit.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got t=%0t expected finish", $time);
        $fatal(1, "timeout");
    end

endmodule
